branch_predict_unit: RTL and testbench

//   Parametrised fetch-stage predictor combining a direct-mapped, fully tagged BTB

---
 rtl/branch_predict_unit.sv | 111 +++++++++++
 tb/tb_branch_predict_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: tagged direct-mapped BTB with 2-bit counters and a speculative return address stack
module branch_predict_unit #(
    parameter int ENTRIES   = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Fetch_En,
    input  logic [31:0] PC_F,
    output logic        Hit_F,
    output logic        Predict_Taken_F,
    output logic [31:0] PC_Prediction_F,
    input  logic        Valid_E,
    input  logic        Branch_Taken_E,
    input  logic [1:0]  Kind_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] PC_Target_E
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int RAS_W = $clog2(RAS_DEPTH);
    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_CALL   = 2'b10;
    localparam logic [1:0] K_RET    = 2'b11;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         kind_q   [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        ras_q    [RAS_DEPTH];
    logic [RAS_W-1:0]   ras_ptr_q;
    logic [RAS_W:0]     ras_cnt_q;

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic [1:0]       kind_f, ctr_e, ctr_next;
    logic [RAS_W-1:0] ras_top_idx;
    logic             ras_empty, ras_full, ret_from_ras;
    logic             hit_e, wr_e, push, pop;
    logic             unused_pc;

    assign unused_pc = ^{PC_F[1:0], PC_E[1:0]};

    // fetch-side lookup: pure function of PC_F and pre-edge table/RAS state
    always_comb begin
        idx_f           = PC_F[IDX_W+1:2];
        tag_f           = PC_F[31:IDX_W+2];
        kind_f          = kind_q[idx_f];
        ras_top_idx     = ras_ptr_q - 1'b1;
        ras_empty       = ras_cnt_q == '0;
        ras_full        = ras_cnt_q == (RAS_W+1)'(RAS_DEPTH);
        Hit_F           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        Predict_Taken_F = Hit_F && (kind_f != K_BRANCH || ctr_q[idx_f][1]);
        ret_from_ras    = Hit_F && kind_f == K_RET && !ras_empty;
        PC_Prediction_F = ret_from_ras ? ras_q[ras_top_idx] : Hit_F ? target_q[idx_f] : 32'd0;
        push            = Fetch_En && Predict_Taken_F && kind_f == K_CALL;
        pop             = Fetch_En && Predict_Taken_F && ret_from_ras;
    end

    // execute-side training decision; RST suppresses every table write
    always_comb begin
        idx_e    = PC_E[IDX_W+1:2];
        tag_e    = PC_E[31:IDX_W+2];
        hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        ctr_e    = ctr_q[idx_e];
        ctr_next = !hit_e ? 2'd2
                 : Branch_Taken_E ? (ctr_e == 2'd3 ? 2'd3 : ctr_e + 2'd1)
                 : (ctr_e == 2'd0 ? 2'd0 : ctr_e - 2'd1);
        wr_e     = !RST && Valid_E && (hit_e || Branch_Taken_E);
    end

    // valid bits: cleared by reset, set when a taken miss allocates
    always_ff @(posedge CLK) begin
        if (RST)
            valid_q <= '0;
        else if (Valid_E && Branch_Taken_E && !hit_e)
            valid_q[idx_e] <= 1'b1;
    end

    // BTB payload: counter on any hit or allocation, tag/target/kind only on taken
    always_ff @(posedge CLK) begin
        if (wr_e)
            ctr_q[idx_e] <= ctr_next;
        if (wr_e && Branch_Taken_E) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= PC_Target_E;
            kind_q[idx_e]   <= Kind_E;
        end
    end

    // RAS pointer and occupancy; a push when full drops the oldest entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (push) begin
            ras_ptr_q <= ras_ptr_q + 1'b1;
            ras_cnt_q <= ras_full ? ras_cnt_q : ras_cnt_q + 1'b1;
        end else if (pop) begin
            ras_ptr_q <= ras_ptr_q - 1'b1;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end

    // RAS storage: return address of the fetched call
    always_ff @(posedge CLK) begin
        if (!RST && push)
            ras_q[ras_ptr_q] <= PC_F + 32'd4;
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        Fetch_En;
    logic [31:0] PC_F;
    logic        Hit_F;
    logic        Predict_Taken_F;
    logic [31:0] PC_Prediction_F;
    logic        Valid_E;
    logic        Branch_Taken_E;
    logic [1:0]  Kind_E;
    logic [31:0] PC_E;
    logic [31:0] PC_Target_E;

    localparam logic [1:0] BR = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

    typedef struct {
        logic        hit;
        logic        tk;
        logic [31:0] pred;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic sample = 1'b0;
    int   nid    = 0;
    int   checks = 0;
    int   errors = 0;

    branch_predict_unit #(.ENTRIES(64), .RAS_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .Fetch_En(Fetch_En), .PC_F(PC_F),
        .Hit_F(Hit_F), .Predict_Taken_F(Predict_Taken_F), .PC_Prediction_F(PC_Prediction_F),
        .Valid_E(Valid_E), .Branch_Taken_E(Branch_Taken_E), .Kind_E(Kind_E),
        .PC_E(PC_E), .PC_Target_E(PC_Target_E)
    );

    always #5 CLK = ~CLK;

    // one cycle of stimulus; when chk is set the expected lookup is queued for the monitor
    task automatic cyc(input logic fe, input logic [31:0] pcf, input logic ve, input logic tk,
                       input logic [1:0] kd, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic chk, input logic eh, input logic et, input logic [31:0] ep);
        exp_t x;
        Fetch_En = fe; PC_F = pcf; Valid_E = ve; Branch_Taken_E = tk;
        Kind_E = kd; PC_E = pce; PC_Target_E = tgt; sample = chk;
        if (chk) begin
            x.hit = eh; x.tk = et; x.pred = ep; x.id = nid;
            q.push_back(x);
            nid++;
        end
        @(posedge CLK);
        #1;
        sample = 1'b0;
    endtask

    task automatic train(input logic [1:0] kd, input logic [31:0] pce, input logic [31:0] tgt, input logic tk);
        cyc(1'b0, 32'hFFF0, 1'b1, tk, kd, pce, tgt, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic look(input logic [31:0] pcf, input logic fe, input logic eh, input logic et, input logic [31:0] ep);
        cyc(fe, pcf, 1'b0, 1'b0, BR, 32'd0, 32'd0, 1'b1, eh, et, ep);
    endtask

    // monitor: compares the lookup outputs mid-cycle against the oldest queued expectation
    always @(negedge CLK) begin
        if (sample) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard empty at time %0t", $time);
            end else begin
                e = q.pop_front();
                if (Hit_F !== e.hit || Predict_Taken_F !== e.tk || PC_Prediction_F !== e.pred) begin
                    errors++;
                    $display("FAIL chk%0d got hit=%b taken=%b pred=%h expected hit=%b taken=%b pred=%h",
                             e.id, Hit_F, Predict_Taken_F, PC_Prediction_F, e.hit, e.tk, e.pred);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; Fetch_En = 1'b0; PC_F = 32'd0; Valid_E = 1'b0; Branch_Taken_E = 1'b0;
        Kind_E = BR; PC_E = 32'd0; PC_Target_E = 32'd0;
        @(posedge CLK);
        #1;
        look(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        RST = 1'b0;
        look(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        // counter walk on a branch at 0x100
        train(BR, 32'h100, 32'h40, 1'b1);
        look(32'h100, 1'b0, 1'b1, 1'b1, 32'h40);
        train(BR, 32'h100, 32'h40, 1'b0);
        look(32'h100, 1'b0, 1'b1, 1'b0, 32'h40);
        train(BR, 32'h100, 32'h40, 1'b0);
        look(32'h100, 1'b0, 1'b1, 1'b0, 32'h40);
        train(BR, 32'h100, 32'h40, 1'b0);
        train(BR, 32'h100, 32'h40, 1'b1);
        look(32'h100, 1'b0, 1'b1, 1'b0, 32'h40);
        train(BR, 32'h100, 32'h40, 1'b1);
        look(32'h100, 1'b0, 1'b1, 1'b1, 32'h40);
        train(BR, 32'h100, 32'h40, 1'b1);
        train(BR, 32'h100, 32'h40, 1'b1);
        train(BR, 32'h100, 32'h40, 1'b1);
        train(BR, 32'h100, 32'h40, 1'b0);
        look(32'h100, 1'b0, 1'b1, 1'b1, 32'h40);
        // same-cycle lookup sees pre-edge counter 2, update lands next cycle
        cyc(1'b0, 32'h100, 1'b1, 1'b0, BR, 32'h100, 32'h40, 1'b1, 1'b1, 1'b1, 32'h40);
        look(32'h100, 1'b0, 1'b1, 1'b0, 32'h40);
        // taken hit rewrites target, not-taken hit keeps it
        train(BR, 32'h100, 32'h44, 1'b1);
        look(32'h100, 1'b0, 1'b1, 1'b1, 32'h44);
        train(BR, 32'h100, 32'h48, 1'b0);
        look(32'h100, 1'b0, 1'b1, 1'b0, 32'h44);
        // alias: 0x200 shares the index of 0x100
        train(JMP, 32'h200, 32'h500, 1'b1);
        look(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h200, 1'b0, 1'b1, 1'b1, 32'h500);
        train(BR, 32'h100, 32'h40, 1'b0);
        look(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h200, 1'b0, 1'b1, 1'b1, 32'h500);
        // call/return pairing
        train(CALL, 32'h80, 32'h1000, 1'b1);
        train(RET, 32'h300, 32'h999, 1'b1);
        look(32'h80, 1'b1, 1'b1, 1'b1, 32'h1000);
        look(32'h300, 1'b1, 1'b1, 1'b1, 32'h84);
        look(32'h300, 1'b1, 1'b1, 1'b1, 32'h999);
        look(32'h80, 1'b0, 1'b1, 1'b1, 32'h1000);
        look(32'h300, 1'b1, 1'b1, 1'b1, 32'h999);
        // overflow: nine calls into an eight-deep stack, then nine returns
        for (int i = 0; i < 9; i++) train(CALL, 32'h2004 + 32'(8 * i), 32'h7000, 1'b1);
        for (int i = 0; i < 9; i++) look(32'h2004 + 32'(8 * i), 1'b1, 1'b1, 1'b1, 32'h7000);
        for (int i = 8; i >= 1; i--) look(32'h300, 1'b1, 1'b1, 1'b1, 32'h2008 + 32'(8 * i));
        look(32'h300, 1'b1, 1'b1, 1'b1, 32'h999);
        // reset beats a concurrent training write and clears the table
        RST = 1'b1;
        train(BR, 32'h400, 32'h77, 1'b1);
        RST = 1'b0;
        look(32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
